cic_pdm_decim: RTL and testbench
================================

Name: cic_pdm_decim

Overview:
Multi-channel, parametrised-order CIC decimator that converts NUM_CH 1-bit PDM streams to signed PCM. Integrators run per channel on every PDM strobe. A single time-shared comb engine processes all channels once per decimation period. Results are rounded, saturated, tagged with a channel index, and delivered through a small output FIFO with valid/ready handshake. It sits between the PDM microphone front-end and the PCM DSP chain.

Parameters:
NUM_CH, 2, number of PDM channels (1..8)
ORDER, 3, CIC order, N integrators and N combs (1..5)
DECIM, 64, decimation factor in PDM strobes (power of two, 8..256)
OUT_W, 16, PCM output width
SHIFT, ORDER*log2(DECIM)+1-OUT_W, arithmetic right shift applied before rounding
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pdm_en  in  1  PDM sample strobe; pdm_in is sampled only when high
pdm_in  in  NUM_CH  PDM bit per channel
pcm_data  out  OUT_W  signed PCM sample at FIFO head
pcm_ch  out  max(1,clog2(NUM_CH))  channel index of pcm_data
pcm_valid  out  1  FIFO non-empty
pcm_ready  in  1  consumer accepts the head entry when pcm_valid&&pcm_ready
err_clear  in  1  clears sticky error flags
err_overrun  out  1  sticky: decimation boundary reached while comb engine busy
err_overflow  out  1  sticky: push attempted into full FIFO

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset clears all integrators, snapshots, comb delays, counters, warm-up state, FIFO and error flags. All outputs read 0 the cycle after rst is sampled high. Reset mid-operation aborts the comb engine and discards the FIFO contents.
- Width: ACC_W = ORDER*log2(DECIM)+1. All integrator and comb arithmetic is modulo 2^ACC_W. Integrator wrap-around is legal and must not be saturated.
- Input mapping: pdm bit 1 -> +1, bit 0 -> -1.
- Integrators: on a pdm_en cycle, stage 0 adds the mapped input and stage k adds stage k-1's registered value (pipelined, same as the classic form). Integrators hold when pdm_en is low.
- Decimation counter: 0..DECIM-1, advances on pdm_en. When a pdm_en cycle has count==DECIM-1, the final-integrator values of all channels are copied into snapshot registers (the snapshot cycle T) and the counter wraps to 0.
- Comb engine FSM:
  - IDLE -> COMB on snapshot.
  - COMB evaluates one stage per cycle: y_k = x_k - d_k; d_k <= x_k. ORDER cycles per channel.
  - COMB -> OUT: round, saturate, and push to the FIFO.
  - OUT -> COMB for the next channel, or OUT -> IDLE after channel NUM_CH-1.
  - Channel c is pushed at cycle T+(c+1)*(ORDER+1). It is visible on pcm_data at T+(c+1)*(ORDER+1)+1 if the FIFO was empty.
- Overrun: a snapshot arriving while the FSM is not IDLE is dropped, sets err_overrun, and the engine continues undisturbed.
- Rounding and saturation: r = (y + 2^(SHIFT-1)) >>> SHIFT (no rounding term if SHIFT==0), computed in ACC_W+1 bits. r is then clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Warm-up: for each channel, the first ORDER comb results after reset are computed (delays updated) but not pushed.
- FIFO: first-word-fall-through.
  - Simultaneous push and pop when full is allowed: the pop frees a slot and the push succeeds, with no overflow.
  - Push when full and no pop: the sample is dropped and err_overflow is set.
  - Pop when empty is ignored.
- Error flags: err_clear clears both flags. If a set condition occurs in the same cycle as err_clear, set wins.
- Throughput requirement, documented rather than checked: DECIM * (pdm_en spacing) >= NUM_CH*(ORDER+1)+1.

Decomposition:
- Package cic_pdm_pkg holds:
  - clog2 helper
  - acc_w(ORDER,DECIM) function
  - sat_round function (input width, SHIFT, OUT_W)
  - FSM state enum {IDLE, COMB, OUT}
- Sub-module cic_out_fifo: synchronous FWFT FIFO, parametrised by width and depth, with push/pop/full/empty. Its data word is {ch, pcm}.

Test Plan:
1. Defaults, pdm_en every cycle, both channels all-ones: after warm-up, every sample is 32767. 64^3=262144, which shifted by 3 is 32768, saturated to 32767. pcm_ch alternates 0,1.
2. Channel 0 all-zeros, channel 1 alternating 1/0 -> channel 0 steady at -32768 and channel 1 steady at 0.
3. One snapshot timing check: the first pushed channel 0 sample appears on pcm_valid exactly 5 cycles after the snapshot cycle; channel 1 appears 4 cycles later. Zero samples are emitted for the first 3 decimation periods.
4. pcm_ready held low for 3 decimation periods, FIFO_DEPTH=4, NUM_CH=2 -> 4 entries retained in order and err_overflow set. Releasing ready then drains ch0,ch1,ch0,ch1. err_clear then drops the flag.
5. DECIM=8, ORDER=5, NUM_CH=2, pdm_en every cycle (requires 13 > 8 cycles) -> err_overrun set, and output samples remain correctly tagged.
6. Assert rst mid-COMB with the FIFO holding 2 entries -> next cycle pcm_valid=0 and flags 0, and warm-up suppression restarts (first 3 results per channel dropped).

Source files
------------

// File: rtl/cic_pdm_pkg.sv
// Shared helpers and types for the multi-channel PDM CIC decimator.
package cic_pdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMB = 2'd1,
        OUT  = 2'd2
    } cic_state_e;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Nominal CIC register growth for a +/-1 input.
    function automatic int acc_w(input int order, input int decim);
        return order * clog2(decim) + 1;
    endfunction

    // Round-half-up arithmetic shift followed by clamp to a signed out_w range.
    // The caller sign-extends into 64 bits; the shift never overflows there.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] y,
                                                     input int shift,
                                                     input int out_w);
        logic signed [63:0] t;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        t = y;
        if (shift > 0) t = (y + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (t > hi)      t = hi;
        else if (t < lo) t = lo;
        return t;
    endfunction

endpackage

// File: rtl/cic_out_fifo.sv
// First-word-fall-through output FIFO. A pop in the same cycle as a push
// into a full FIFO frees the slot, so the push is accepted.
module cic_out_fifo
    import cic_pdm_pkg::*;
#(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == FULL_CNT);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Head reads 0 while empty so the PCM outputs are quiet after reset.
    assign o_rdata   = o_empty ? '0 : r_mem[r_rp];

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp] <= i_wdata;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + AW'(1);
            if (w_do_pop)  r_rp <= r_rp + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/cic_pdm_decim.sv
// Multi-channel PDM -> PCM CIC decimator: per-channel integrators at the PDM
// strobe rate, one time-shared comb engine per decimation period, rounding,
// saturation, channel tagging and a small FWFT output FIFO.
module cic_pdm_decim
    import cic_pdm_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ORDER      = 3,
    parameter int DECIM      = 64,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = ORDER * clog2(DECIM) + 1 - OUT_W,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pdm_en,
    input  logic [NUM_CH-1:0] i_pdm_in,
    output logic [OUT_W-1:0]  o_pcm_data,
    output logic [CH_W-1:0]   o_pcm_ch,
    output logic              o_pcm_valid,
    input  logic              i_pcm_ready,
    input  logic              i_err_clear,
    output logic              o_err_overrun,
    output logic              o_err_overflow
);
    // One guard bit over the nominal growth keeps +DECIM^ORDER and
    // -DECIM^ORDER distinct, so full-scale inputs saturate to the right rail.
    localparam int ACC_W = acc_w(ORDER, DECIM);
    localparam int DP_W  = ACC_W + 1;
    localparam int CNT_W = clog2(DECIM);
    localparam int STG_W = (ORDER > 1) ? clog2(ORDER) : 1;
    localparam int WRM_W = clog2(ORDER + 1);
    localparam int FW    = CH_W + OUT_W;

    logic [NUM_CH-1:0][ORDER-1:0][DP_W-1:0] r_integ;
    logic [NUM_CH-1:0][DP_W-1:0]            r_snap;
    logic [NUM_CH-1:0][ORDER-1:0][DP_W-1:0] r_dly;
    logic [NUM_CH-1:0][WRM_W-1:0]           r_warm;
    logic [CNT_W-1:0]                       r_cnt;
    cic_state_e                             r_state;
    cic_state_e                             w_state_nxt;
    logic [STG_W-1:0]                       r_stage;
    logic [CH_W-1:0]                        r_ch;
    logic [CH_W-1:0]                        w_ch_nxt;
    logic [DP_W-1:0]                        r_x;
    logic                                   r_err_overrun;
    logic                                   r_err_overflow;

    logic             w_snap;
    logic             w_warm_done;
    logic             w_push;
    logic [OUT_W-1:0] w_pcm;
    logic [FW-1:0]    w_rdata;
    logic             w_full;
    logic             w_empty;

    assign w_snap      = i_pdm_en && (r_cnt == CNT_W'(DECIM - 1));
    assign w_warm_done = (r_warm[r_ch] == WRM_W'(ORDER));
    assign w_ch_nxt    = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
    assign w_pcm       = OUT_W'(sat_round(64'(signed'(r_x)), SHIFT, OUT_W));

    // Integrator cascade per channel; stage k consumes stage k-1's registered value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_integ <= '0;
        end else if (i_pdm_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_integ[c][0] <= r_integ[c][0] + (i_pdm_in[c] ? DP_W'(1) : {DP_W{1'b1}});
                for (int k = 1; k < ORDER; k++) begin
                    r_integ[c][k] <= r_integ[c][k] + r_integ[c][k-1];
                end
            end
        end
    end

    // Decimation counter and snapshot capture; a snapshot while busy is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_snap <= '0;
        end else if (i_pdm_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_snap && r_state == IDLE) begin
                for (int c = 0; c < NUM_CH; c++) r_snap[c] <= r_integ[c][ORDER-1];
            end
        end
    end

    // Comb engine state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Comb engine next state and FIFO push request.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            IDLE: if (w_snap) w_state_nxt = COMB;
            COMB: if (r_stage == STG_W'(ORDER - 1)) w_state_nxt = OUT;
            OUT: begin
                w_push      = w_warm_done;
                w_state_nxt = (r_ch == CH_W'(NUM_CH - 1)) ? IDLE : COMB;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Comb datapath: one stage per cycle through a single working register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_stage <= '0;
            r_ch    <= '0;
            r_dly   <= '0;
            r_warm  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_snap) begin
                        r_x     <= r_integ[0][ORDER-1];
                        r_stage <= '0;
                        r_ch    <= '0;
                    end
                end
                COMB: begin
                    r_x                  <= r_x - r_dly[r_ch][r_stage];
                    r_dly[r_ch][r_stage] <= r_x;
                    r_stage              <= r_stage + STG_W'(1);
                end
                OUT: begin
                    if (!w_warm_done) r_warm[r_ch] <= r_warm[r_ch] + WRM_W'(1);
                    r_stage <= '0;
                    r_ch    <= w_ch_nxt;
                    r_x     <= r_snap[w_ch_nxt];
                end
                default: r_stage <= '0;
            endcase
        end
    end

    // Sticky error flags; a set condition outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_overrun  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_snap && r_state != IDLE) r_err_overrun <= 1'b1;
            else if (i_err_clear)          r_err_overrun <= 1'b0;
            if (w_push && w_full && !i_pcm_ready) r_err_overflow <= 1'b1;
            else if (i_err_clear)                 r_err_overflow <= 1'b0;
        end
    end

    cic_out_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (i_pcm_ready),
        .i_wdata ({r_ch, w_pcm}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_pcm_valid    = !w_empty;
    assign o_pcm_ch       = w_rdata[FW-1:OUT_W];
    assign o_pcm_data     = w_rdata[OUT_W-1:0];
    assign o_err_overrun  = r_err_overrun;
    assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_cic_pdm_decim.sv
// Bench for cic_pdm_decim: steady-state pattern table, timing/warm-up,
// FIFO full/overflow, mid-comb reset, randomized model comparison, overrun.
module tb_cic_pdm_decim;

    localparam int NCH = 2;
    localparam int ORD = 3;
    localparam int DEC = 64;
    localparam int SH  = 3;
    localparam int OW  = 16;
    localparam int L   = ORD * (DEC - 1) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pdm_en, pcm_ready, err_clear;
    logic [1:0]  pdm_in;
    logic [15:0] pcm_data;
    logic [0:0]  pcm_ch;
    logic        pcm_valid, e_ovr, e_ovf;

    logic        rst2, en2, rdy2, clr2;
    logic [1:0]  in2;
    logic [15:0] data2;
    logic [0:0]  ch2;
    logic        v2, ovr2, ovf2;

    cic_pdm_decim dut (
        .clk(clk), .rst(rst), .i_pdm_en(pdm_en), .i_pdm_in(pdm_in),
        .o_pcm_data(pcm_data), .o_pcm_ch(pcm_ch), .o_pcm_valid(pcm_valid),
        .i_pcm_ready(pcm_ready), .i_err_clear(err_clear),
        .o_err_overrun(e_ovr), .o_err_overflow(e_ovf)
    );

    cic_pdm_decim #(.NUM_CH(2), .ORDER(5), .DECIM(8)) dut_ov (
        .clk(clk), .rst(rst2), .i_pdm_en(en2), .i_pdm_in(in2),
        .o_pcm_data(data2), .o_pcm_ch(ch2), .o_pcm_valid(v2),
        .i_pcm_ready(rdy2), .i_err_clear(clr2),
        .o_err_overrun(ovr2), .o_err_overflow(ovf2)
    );

    typedef struct { int ch; longint val; } exp_t;
    typedef struct { logic [3:0] p0; logic [3:0] p1; int e0; int e1; } vec_t;

    int     total = 0;
    int     bad   = 0;
    longint h [L];
    longint hn[L];
    int     xs[NCH][$];
    exp_t   expq[$];
    int     got_ch[$];
    int     got_val[$];
    int     strb;
    bit     sb_on;
    logic        s_valid;
    logic [0:0]  s_ch;
    logic [15:0] s_data;
    vec_t   tbl[4];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: CIC output as a direct FIR with the (boxcar)^ORDER kernel,
    // then round-half-up shift and clamp using plain integer arithmetic.
    function automatic longint model(int c, int t);
        longint acc;
        acc = 0;
        for (int i = 0; i < L; i++) if (t - i >= 0) acc += h[i] * xs[c][t-i];
        acc = (acc + (64'sd1 <<< (SH - 1))) >>> SH;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic tick(input logic en, input logic [1:0] bits, input logic rdy);
        exp_t e;
        @(negedge clk);
        s_valid = pcm_valid; s_ch = pcm_ch; s_data = pcm_data;
        if (pcm_valid && rdy) begin
            got_ch.push_back(int'(pcm_ch));
            got_val.push_back(int'($signed(pcm_data)));
            if (sb_on) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected: got ch %0d data %0d expected no sample", pcm_ch, $signed(pcm_data));
                end else begin
                    e = expq.pop_front();
                    chk("sb_ch", pcm_ch, e.ch);
                    chk("sb_val", $signed(pcm_data), e.val);
                end
            end
        end
        pdm_en = en; pdm_in = bits; pcm_ready = rdy;
        if (en) begin
            for (int c = 0; c < NCH; c++) xs[c].push_back(bits[c] ? 1 : -1);
            if ((strb % DEC) == DEC - 1 && (strb / DEC) >= ORD)
                for (int c = 0; c < NCH; c++) begin
                    e.ch = c; e.val = model(c, strb - ORD);
                    expq.push_back(e);
                end
            strb++;
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) xs[c].delete();
        expq.delete(); got_ch.delete(); got_val.delete();
        strb = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pdm_en = 1'b0; pcm_ready = 1'b0; err_clear = 1'b0;
        @(negedge clk);
        chk("rst_valid", pcm_valid, 0);
        chk("rst_data", pcm_data, 0);
        chk("rst_ovr", e_ovr, 0);
        chk("rst_ovf", e_ovf, 0);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic run_timing(input string name);
        int first, second, fch, sch, fval;
        first = -1; second = -1; fch = -1; sch = -1; fval = 0;
        for (int i = 0; i < 272; i++) begin
            tick(1'b1, 2'b11, 1'b1);
            if (s_valid) begin
                if (first < 0) begin first = i; fch = s_ch; fval = int'($signed(s_data)); end
                else if (second < 0) begin second = i; sch = s_ch; end
            end
        end
        chk({name, "_first_cycle"}, first, 260);
        chk({name, "_first_ch"}, fch, 0);
        chk({name, "_first_val"}, fval, 32767);
        chk({name, "_second_cycle"}, second, 264);
        chk({name, "_second_ch"}, sch, 1);
    endtask

    initial begin
        int nxt, npop, seen;
        rst = 1'b1; pdm_en = 1'b0; pdm_in = '0; pcm_ready = 1'b0; err_clear = 1'b0;
        rst2 = 1'b1; en2 = 1'b0; in2 = '0; rdy2 = 1'b1; clr2 = 1'b0;
        sb_on = 1'b0;

        for (int i = 0; i < L; i++) h[i] = 0;
        h[0] = 1;
        for (int n = 0; n < ORD; n++) begin
            for (int j = 0; j < L; j++) begin
                hn[j] = 0;
                for (int k = 0; k < DEC; k++) if (j - k >= 0) hn[j] += h[j-k];
            end
            h = hn;
        end

        tbl[0] = '{4'b1111, 4'b1111,  32767,  32767};
        tbl[1] = '{4'b0000, 4'b0101, -32768,      0};
        tbl[2] = '{4'b0001, 4'b0111, -16384,  16384};
        tbl[3] = '{4'b0101, 4'b1111,      0,  32767};

        // Latency from snapshot and warm-up suppression.
        do_reset();
        run_timing("timing");

        // Steady-state pattern table.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < 400; i++)
                tick(1'b1, {tbl[v].p1[i%4], tbl[v].p0[i%4]}, 1'b1);
            chk("tbl_count", got_ch.size(), 6);
            for (int k = 0; k < got_ch.size(); k++) begin
                chk("tbl_ch", got_ch[k], k % 2);
                chk("tbl_val", got_val[k], (k % 2) ? tbl[v].e1 : tbl[v].e0);
            end
        end

        // FIFO full: pop+push in the same cycle, then true overflow, drain, clear.
        do_reset();
        for (int i = 0; i < 470; i++) begin
            tick(1'b1, 2'b01, (i == 387 || i == 391));
            if (i == 400) chk("full_pushpop_ovf", e_ovf, 0);
        end
        chk("full_ovf_set", e_ovf, 1);
        chk("full_valid", pcm_valid, 1);
        chk("full_ovr", e_ovr, 0);
        for (int i = 0; i < 8; i++) tick(1'b0, 2'b00, 1'b1);
        chk("drain_count", got_ch.size(), 6);
        for (int k = 0; k < got_ch.size(); k++) begin
            chk("drain_ch", got_ch[k], k % 2);
            chk("drain_val", got_val[k], (k % 2) ? -32768 : 32767);
        end
        chk("drain_empty", pcm_valid, 0);
        chk("ovf_sticky", e_ovf, 1);
        err_clear = 1'b1;
        tick(1'b0, 2'b00, 1'b1);
        err_clear = 1'b0;
        tick(1'b0, 2'b00, 1'b1);
        chk("ovf_cleared", e_ovf, 0);

        // Reset while the comb engine is busy and the FIFO holds two entries.
        do_reset();
        for (int i = 0; i < 321; i++) tick(1'b1, 2'b11, 1'b0);
        @(negedge clk);
        chk("prerst_valid", pcm_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", pcm_valid, 0);
        chk("midrst_data", pcm_data, 0);
        chk("midrst_ch", pcm_ch, 0);
        chk("midrst_ovr", e_ovr, 0);
        chk("midrst_ovf", e_ovf, 0);
        rst = 1'b0; pdm_en = 1'b0;
        clear_model();
        run_timing("after_rst");

        // Randomized stimulus against the reference model.
        do_reset();
        sb_on = 1'b1;
        for (int i = 0; i < 4000; i++)
            tick(1'($urandom_range(0, 1)), 2'($urandom), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 20; i++) tick(1'b0, 2'b00, 1'b1);
        sb_on = 1'b0;
        chk("rand_leftover", expq.size(), 0);
        chk("rand_ovr", e_ovr, 0);
        chk("rand_ovf", e_ovf, 0);

        // Overrun: DECIM=8, ORDER=5 with a strobe every cycle.
        @(negedge clk);
        chk("ov_rst_valid", v2, 0);
        chk("ov_rst_ovr", ovr2, 0);
        rst2 = 1'b0;
        nxt = 0; npop = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (v2) begin
                chk("ov_ch_tag", ch2, nxt);
                nxt ^= 1; npop++;
            end
            en2 = 1'b1; in2 = 2'($urandom); rdy2 = 1'b1;
        end
        chk("ov_flag", ovr2, 1);
        chk("ov_pops", (npop > 4), 1);
        chk("ov_no_ovf", ovf2, 0);
        seen = 0;
        clr2 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ovr2) seen++;
        end
        chk("ov_set_wins", (seen > 0), 1);
        en2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ov_cleared", ovr2, 0);
        clr2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
